// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: converts a single-outstanding command/response
// interface into AXI-Lite read and write transactions.
module axi_lite_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // command side
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
  // response side
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  // AW channel
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  // W channel
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  // B channel
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  // AR channel
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  // R channel
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [1:0]              i_rresp,
  input  logic [DATA_WIDTH-1:0]   i_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESPOND
  } state_e;

  state_e                  state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs;

  // State and payload registers, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Next-state and payload capture; AW and W completion tracked separately
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_hs       = o_awvalid && i_awready;
    w_hs        = o_wvalid && i_wready;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_d    = i_cmd_addr;
          wdata_d   = i_cmd_wdata;
          wstrb_d   = i_cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = i_cmd_write ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = i_bresp;
          state_d     = RESPOND;
        end
      end
      RD_ADDR: begin
        if (i_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (i_rvalid) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = i_rdata;
          rsp_resp_d  = i_rresp;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel handshake outputs decoded from registered state only
  always_comb begin
    o_cmd_ready = (state_q == IDLE) && !rst;
    o_awvalid   = (state_q == WR_ADDR_DATA) && !aw_done_q;
    o_wvalid    = (state_q == WR_ADDR_DATA) && !w_done_q;
    o_bready    = (state_q == WR_RESP);
    o_arvalid   = (state_q == RD_ADDR);
    o_rready    = (state_q == RD_DATA);
    o_rsp_valid = (state_q == RESPOND);
    o_awaddr    = addr_q;
    o_araddr    = addr_q;
    o_wdata     = wdata_q;
    o_wstrb     = wstrb_q;
    o_rsp_write = rsp_write_q;
    o_rsp_rdata = rsp_rdata_q;
    o_rsp_resp  = rsp_resp_q;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
AXI4-Lite initiator that turns a simple single-outstanding command/response interface into AXI-Lite read and write transactions. It is the counterpart of axi_lite_demo and drives its five channels directly, so benches and firmware-side logic can reach the slave without a cocotb driver. Exactly one transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)
STROBE_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
i_cmd_valid  input  1  command request
o_cmd_ready  output  1  command accept; high only in IDLE and not in reset
i_cmd_write  input  1  1=write, 0=read
i_cmd_addr  input  ADDR_WIDTH  transaction address
i_cmd_wdata  input  DATA_WIDTH  write data
i_cmd_wstrb  input  STROBE_WIDTH  write strobes
o_rsp_valid  output  1  response available
i_rsp_ready  input  1  response consumed
o_rsp_write  output  1  echo of command type
o_rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
o_rsp_resp  output  2  captured BRESP/RRESP
o_awvalid  output  1  AW valid
o_awaddr  output  ADDR_WIDTH  AW address
i_awready  input  1  AW ready
o_wvalid  output  1  W valid
i_wready  input  1  W ready
o_wstrb  output  STROBE_WIDTH  W strobes
o_wdata  output  DATA_WIDTH  W data
i_bvalid  input  1  B valid
o_bready  output  1  B ready
i_bresp  input  2  B response
o_arvalid  output  1  AR valid
i_arready  input  1  AR ready
o_araddr  output  ADDR_WIDTH  AR address
i_rvalid  input  1  R valid
o_rready  output  1  R ready
i_rresp  input  2  R response
i_rdata  input  DATA_WIDTH  R data

Behaviour:
- Reset (async, immediate): state=IDLE; all valid/ready outputs 0, o_cmd_ready 0 while rst high; rsp fields, addr, data, strb 0. Mid-transaction reset drops valids at once, in-flight transaction discarded, no response.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE: o_cmd_ready=1. On i_cmd_valid&&o_cmd_ready, register addr/wdata/wstrb/type. Next cycle: write -> WR_ADDR_DATA with o_awvalid=o_wvalid=1; read -> RD_ADDR with o_arvalid=1.
- WR_ADDR_DATA: AW and W issued concurrently and tracked independently (aw_done, w_done). Each valid falls the cycle after its own handshake; the other stays high until it completes. Same-cycle AW and W handshakes are legal. When both are done -> WR_RESP, o_bready=1 next cycle.
- WR_RESP: on i_bvalid&&o_bready capture i_bresp, o_bready->0, go RESPOND. i_bvalid while o_bready=0 is ignored.
- RD_ADDR: o_arvalid held until i_arready, then RD_DATA with o_rready=1 next cycle.
- RD_DATA: on i_rvalid&&o_rready capture i_rdata and i_rresp, o_rready->0, go RESPOND.
- RESPOND: o_rsp_valid=1 and fields stable until i_rsp_ready, then IDLE. Response fields hold their value after handoff. SLVERR/DECERR are passed through unmodified with no retry.
- AXI rules: a valid never drops before its handshake; payload is stable while valid is high; no combinational path from any input to any output except o_cmd_ready, which is decoded from state and rst.
- Minimum latency, zero-wait slave: command accept cycle 0, AW/W or AR valid cycle 1, BREADY/RREADY cycle 2, o_rsp_valid cycle 3. Back-to-back commands use 1 idle cycle for the IDLE re-entry.

Test Plan:
- Write 0x00000004 data 0xDEADBEEF strb 0xF, slave always ready, BRESP=0 -> AW/W valid in cycle 1, o_rsp_valid cycle 3, resp 0, rdata 0.
- Read 0x00000004 after that write -> ARADDR 0x4, o_rsp_rdata 0xDEADBEEF, resp 0, o_rsp_valid cycle 3.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> o_wvalid drops after cycle 1, o_awvalid held to cycle 4, o_bready rises only after both handshakes.
- Slave returns RRESP=2'b10 and i_rsp_ready held low 5 cycles -> o_rsp_resp=2, o_rsp_valid and fields stable all 5 cycles, o_cmd_ready 0 until handoff.
- Assert rst while o_arvalid high, waiting for ARREADY -> o_arvalid 0 in the same cycle, no response; after release a new read completes normally.
- 50 random interleaved reads/writes with random ready/valid stalls against axi_lite_demo -> every read returns the last value written to its address, and no valid drops before its handshake.
